gpio: RTL and testbench
=======================

# gpio

General-purpose I/O peripheral occupying slot 4 of the system I/O block (bus address bits [11:8] = 4). It receives the same simple register-bus strobes as the UART and SPI slots: write strobe with byte select, read strobe with registered read data. It provides per-pin output data and output enable, synchronised input sampling, and per-pin rising/falling edge interrupt capture with a write-1-to-clear pending register. It also drives a single level interrupt to the core.

## Interface
- GPIO_N, 16, number of pins (1..32); register bits at or above GPIO_N read 0 and ignore writes
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset; single clock domain, no other reset
- waddr_i  in  8  byte write address; bits [1:0] ignored
- data_i  in  32  write data
- sel_i  in  4  byte-lane write enables
- we_i  in  1  write strobe, one cycle per write
- raddr_i  in  8  byte read address; bits [1:0] ignored
- rd_i  in  1  read strobe, one cycle per read
- data_o  out  32  registered read data
- gpio_i  in  GPIO_N  asynchronous pin inputs
- gpio_o  out  GPIO_N  pin output values
- gpio_oe  out  GPIO_N  pin output enables, 1 = drive
- irq_o  out  1  level interrupt, equal to |(IP & IE)

## Operation
- Register map (word offsets):
  - 0x00 DOUT: RW
  - 0x04 OE: RW
  - 0x08 DIN: RO, filtered input
  - 0x0C IE: RW
  - 0x10 IRISE: RW, rising-edge capture enable
  - 0x14 IFALL: RW, falling-edge capture enable
  - 0x18 IP: pending; write 1 clears, write 0 has no effect
  - 0x1C DTGL: WO, a 1 toggles the corresponding DOUT bit; reads 0
  - 0x20 DBDIV: see Configuration
  - All other offsets read 0 and ignore writes.
- Byte lanes: for RW registers, only lanes with sel_i[k]=1 update. IP clear and DTGL toggle are also masked per lane.
- gpio_o = DOUT and gpio_oe = OE, both driven directly from registers.
- Input path: two-flop synchroniser, then filter (Configuration), then value s. A delayed copy d of s is kept.
- Edge capture: IP[i] sets when (s[i] & ~d[i] & IRISE[i]) | (~s[i] & d[i] & IFALL[i]). IE gates only irq_o, never capture.
- Simultaneous set and W1C on the same bit in the same cycle: set wins and IP stays 1.
- Read: on rd_i, data_o <= register at raddr_i. data_o holds its value until the next rd_i. A read and a write to the same register in the same cycle return the pre-write value.
- A write to IRISE/IFALL does not generate spurious edges; d keeps tracking s regardless.

## Timing
- Reset values: DOUT, OE, IE, IRISE, IFALL and IP are 0. Synchroniser flops, s and d are 0. data_o, gpio_o, gpio_oe and irq_o are 0.
- Write to DOUT/OE/DTGL at edge N: gpio_o/gpio_oe change after edge N.
- Read strobe at edge N: data_o valid after edge N. The consumer samples it in cycle N+1.
- Pin transition stable before edge N, no filter:
  - s changes after edge N+1.
  - IP sets at edge N+2.
  - irq_o rises after edge N+2 if IE=1.
- Pin pulses shorter than one clock may be missed. This is not an error.
- Reset asserted mid-operation: all state returns to reset values asynchronously, and pins stop driving immediately.

## Configuration
- GPIO_DEBOUNCE_EN defined:
  - DBDIV (RW, 16 bit, reset 0) sets a shared prescaler that produces a tick every DBDIV+1 cycles.
  - On each tick, the synchronised inputs are sampled. s[i] updates only when two consecutive tick samples agree.
  - With DBDIV=0, latency from stable pin to s is 2 to 3 cycles beyond the synchroniser.
  - Writing DBDIV restarts the prescaler at 0.
- GPIO_DEBOUNCE_EN undefined: s equals the synchroniser output, DBDIV reads 0 and writes are ignored, and no prescaler logic exists.

## Structure
- Register offset constants (GPIO_DOUT … GPIO_DBDIV) go in the shared defines file next to the other slot peripherals. Bus widths use the existing memory bus width defines.
- One sub-module, gpio_in_filter: synchroniser plus optional debounce, GPIO_N wide, outputs s. Edge detection, registers and read mux stay in gpio.

## Test plan
- Reset, then read every offset 0x00–0x20: all read 0, and gpio_o=0, gpio_oe=0, irq_o=0.
- Write DOUT=0x1234_A5A5 with sel_i=4'b0001, then read: 0x0000_00A5. Then DTGL=0x0000_00FF: gpio_o=0x005A.
- IRISE=0x0001, IE=0x0001, then gpio_i[0] goes 0→1: IP reads 0x0001 and irq_o=1 exactly 2 cycles after the sampling edge. Write IP=0x0001: irq_o=0.
- IFALL=0x8000 with IE=0, then gpio_i[15] goes 1→0: IP[15]=1 and irq_o=0. Then set IE[15]: irq_o=1 on the next cycle.
- A new rising edge on pin 0 landing in the same cycle as a W1C of IP[0]: IP[0] stays 1.
- With GPIO_DEBOUNCE_EN, DBDIV=9: a 15-cycle glitch on gpio_i[3] leaves DIN[3]=0, while a 40-cycle level sets DIN[3]=1.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the GPIO slot of the system I/O block.
//   - Bus widths for the simple register bus (byte address, 32-bit data).
//   - Register byte offsets within the slot (GPIO_DOUT .. GPIO_DBDIV).
//   - lane_mask(): expands the 4 byte-lane selects into a 32-bit bit mask.
package gpio_pkg;

    localparam int GPIO_AW = 8;   // byte address width inside the slot
    localparam int GPIO_DW = 32;  // bus data width

    localparam logic [7:0] GPIO_DOUT  = 8'h00;
    localparam logic [7:0] GPIO_OE    = 8'h04;
    localparam logic [7:0] GPIO_DIN   = 8'h08;
    localparam logic [7:0] GPIO_IE    = 8'h0C;
    localparam logic [7:0] GPIO_IRISE = 8'h10;
    localparam logic [7:0] GPIO_IFALL = 8'h14;
    localparam logic [7:0] GPIO_IP    = 8'h18;
    localparam logic [7:0] GPIO_DTGL  = 8'h1C;
    localparam logic [7:0] GPIO_DBDIV = 8'h20;

    function automatic logic [GPIO_DW-1:0] lane_mask(input logic [3:0] sel);
        lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: input conditioning for the GPIO pins.
//   Two-flop synchroniser on every pin, optionally followed by a debouncer.
//   Optional feature macro: GPIO_DEBOUNCE_EN.
//     defined   : a shared prescaler ticks every dbdiv_i+1 cycles; on each tick
//                 the synchronised pins are sampled and s_o[i] follows only when
//                 two consecutive tick samples agree. restart_i zeroes the
//                 prescaler.
//     undefined : s_o is the synchroniser output; no prescaler exists.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   dbdiv_i[15:0]     prescaler divisor (debounce build only)
//   restart_i         restart prescaler at 0 (debounce build only)
//   gpio_i[GPIO_N]    asynchronous pin inputs
//   s_o[GPIO_N]       filtered input value
module gpio_in_filter #(
    parameter int GPIO_N = 16
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef GPIO_DEBOUNCE_EN
    input  logic [15:0]       dbdiv_i,
    input  logic              restart_i,
`endif
    input  logic [GPIO_N-1:0] gpio_i,
    output logic [GPIO_N-1:0] s_o
);

    logic [GPIO_N-1:0] sync1_q;
    logic [GPIO_N-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [15:0]       cnt_q;
    logic [GPIO_N-1:0] samp_q;
    logic [GPIO_N-1:0] s_q;
    logic [GPIO_N-1:0] agree;
    logic              tick;

    assign tick  = (cnt_q == dbdiv_i);
    // A bit agrees when the current tick sample matches the previous one.
    assign agree = ~(sync2_q ^ samp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            samp_q <= '0;
            s_q    <= '0;
        end else begin
            if (restart_i || tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (tick) begin
                samp_q <= sync2_q;
                s_q    <= (agree & sync2_q) | (~agree & s_q);
            end
        end
    end

    assign s_o = s_q;
`else
    assign s_o = sync2_q;
`endif

endmodule

// File: rtl/gpio.sv
// gpio: general-purpose I/O peripheral (slot 4 of the system I/O block).
//   Register map (byte offsets): DOUT 0x00, OE 0x04, DIN 0x08 (RO), IE 0x0C,
//   IRISE 0x10, IFALL 0x14, IP 0x18 (W1C), DTGL 0x1C (WO, toggles DOUT),
//   DBDIV 0x20 (debounce build only, otherwise reads 0). Other offsets read 0.
//   Optional feature macro: GPIO_DEBOUNCE_EN (input debouncer + DBDIV register).
// Bus handshake: we_i and rd_i are single-cycle strobes that are always
//   accepted (no ready/stall). Writes apply at the strobe edge under sel_i
//   byte lanes; a read captures the addressed register's pre-write value into
//   data_o at the strobe edge, and data_o holds until the next rd_i.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   waddr_i, data_i, sel_i, we_i   write address/data/lanes/strobe
//   raddr_i, rd_i       read address/strobe
//   data_o              registered read data
//   gpio_i              asynchronous pin inputs
//   gpio_o, gpio_oe     pin output values / output enables (1 = drive)
//   irq_o               level interrupt, |(IP & IE)
module gpio
    import gpio_pkg::*;
#(
    parameter int GPIO_N = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [GPIO_AW-1:0] waddr_i,
    input  logic [GPIO_DW-1:0] data_i,
    input  logic [3:0]         sel_i,
    input  logic               we_i,
    input  logic [GPIO_AW-1:0] raddr_i,
    input  logic               rd_i,
    output logic [GPIO_DW-1:0] data_o,
    input  logic [GPIO_N-1:0]  gpio_i,
    output logic [GPIO_N-1:0]  gpio_o,
    output logic [GPIO_N-1:0]  gpio_oe,
    output logic               irq_o
);

    logic [GPIO_N-1:0]  dout_q, dout_d, oe_q, oe_d, ie_q, ie_d;
    logic [GPIO_N-1:0]  irise_q, irise_d, ifall_q, ifall_d, ip_q, ip_d;
    logic [GPIO_N-1:0]  s, d_q, edge_set, ip_clr, wdata, wmask;
    logic [GPIO_DW-1:0] mask32, data_q, rdata;
    logic [7:0]         waddr_w, raddr_w;
    logic               unused_bits;

    function automatic logic [GPIO_DW-1:0] zext(input logic [GPIO_N-1:0] v);
        zext = '0;
        zext[GPIO_N-1:0] = v;
    endfunction

    assign waddr_w = {waddr_i[7:2], 2'b00};
    assign raddr_w = {raddr_i[7:2], 2'b00};
    assign mask32  = lane_mask(sel_i);
    assign wmask   = mask32[GPIO_N-1:0];
    assign wdata   = data_i[GPIO_N-1:0];
    assign unused_bits = ^{waddr_i[1:0], raddr_i[1:0], data_i, mask32};

`ifdef GPIO_DEBOUNCE_EN
    logic [15:0] dbdiv_q, dbdiv_d;
    logic        dbdiv_wr;

    assign dbdiv_wr = we_i && (waddr_w == GPIO_DBDIV);
    assign dbdiv_d  = (dbdiv_q & ~mask32[15:0]) | (data_i[15:0] & mask32[15:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        dbdiv_q <= '0;
        else if (dbdiv_wr) dbdiv_q <= dbdiv_d;
    end

    gpio_in_filter #(.GPIO_N(GPIO_N)) u_in_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .dbdiv_i   (dbdiv_q),
        .restart_i (dbdiv_wr),
        .gpio_i    (gpio_i),
        .s_o       (s)
    );
`else
    gpio_in_filter #(.GPIO_N(GPIO_N)) u_in_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .gpio_i (gpio_i),
        .s_o    (s)
    );
`endif

    // Capture uses the current enables only; IE gates irq_o, never capture.
    assign edge_set = (s & ~d_q & irise_q) | (~s & d_q & ifall_q);

    always_comb begin
        dout_d  = dout_q;
        oe_d    = oe_q;
        ie_d    = ie_q;
        irise_d = irise_q;
        ifall_d = ifall_q;
        ip_clr  = '0;
        if (we_i) begin
            case (waddr_w)
                GPIO_DOUT:  dout_d  = (dout_q  & ~wmask) | (wdata & wmask);
                GPIO_OE:    oe_d    = (oe_q    & ~wmask) | (wdata & wmask);
                GPIO_IE:    ie_d    = (ie_q    & ~wmask) | (wdata & wmask);
                GPIO_IRISE: irise_d = (irise_q & ~wmask) | (wdata & wmask);
                GPIO_IFALL: ifall_d = (ifall_q & ~wmask) | (wdata & wmask);
                GPIO_IP:    ip_clr  = wdata & wmask;
                GPIO_DTGL:  dout_d  = dout_q ^ (wdata & wmask);
                default: ;
            endcase
        end
        // OR-ing the set term last makes a new edge win over a same-cycle clear.
        ip_d = (ip_q & ~ip_clr) | edge_set;
    end

    always_comb begin
        rdata = '0;
        case (raddr_w)
            GPIO_DOUT:  rdata = zext(dout_q);
            GPIO_OE:    rdata = zext(oe_q);
            GPIO_DIN:   rdata = zext(s);
            GPIO_IE:    rdata = zext(ie_q);
            GPIO_IRISE: rdata = zext(irise_q);
            GPIO_IFALL: rdata = zext(ifall_q);
            GPIO_IP:    rdata = zext(ip_q);
`ifdef GPIO_DEBOUNCE_EN
            GPIO_DBDIV: rdata = {16'd0, dbdiv_q};
`endif
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q  <= '0;
            oe_q    <= '0;
            ie_q    <= '0;
            irise_q <= '0;
            ifall_q <= '0;
            ip_q    <= '0;
            d_q     <= '0;
            data_q  <= '0;
        end else begin
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            ie_q    <= ie_d;
            irise_q <= irise_d;
            ifall_q <= ifall_d;
            ip_q    <= ip_d;
            d_q     <= s;
            if (rd_i) data_q <= rdata;
        end
    end

    assign data_o  = data_q;
    assign gpio_o  = dout_q;
    assign gpio_oe = oe_q;
    assign irq_o   = |(ip_q & ie_q);

endmodule

// File: tb/tb_gpio.sv
module tb_gpio;
    import gpio_pkg::*;

    localparam int N = 16;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   waddr = '0;
    logic [31:0]  wdat = '0;
    logic [3:0]   sel = '0;
    logic         we = 1'b0;
    logic [7:0]   raddr = '0;
    logic         rd = 1'b0;
    logic [31:0]  data_o;
    logic [N-1:0] pins = '0;
    logic [N-1:0] gpio_o, gpio_oe;
    logic         irq_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio #(.GPIO_N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .waddr_i (waddr),
        .data_i  (wdat),
        .sel_i   (sel),
        .we_i    (we),
        .raddr_i (raddr),
        .rd_i    (rd),
        .data_o  (data_o),
        .gpio_i  (pins),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq_o   (irq_o)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks (entered and left at a negedge) ----------------
    task automatic wr(input logic [7:0] a, input logic [31:0] dv, input logic [3:0] s);
        waddr = a; wdat = dv; sel = s; we = 1'b1;
        @(negedge clk);
        we = 1'b0; sel = '0;
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [31:0] dv);
        raddr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        dv = data_o;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] rv;

    initial begin
        // Reset state
        #2;
        check("rst_gpio_o_async", {16'd0, gpio_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_gpio_o", {16'd0, gpio_o}, 32'd0);
        check("rst_gpio_oe", {16'd0, gpio_oe}, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("rst_data_o", data_o, 32'd0);
        for (int i = 0; i <= 9; i++) begin
            rd_reg(8'(i * 4), rv);
            check($sformatf("rst_rd_%02h", i * 4), rv, 32'd0);
        end

        // DOUT lane masking and DTGL
        wr(GPIO_DOUT, 32'h1234_A5A5, 4'b0001);
        rd_reg(GPIO_DOUT, rv);
        check("dout_lane0", rv, 32'h0000_00A5);
        wr(GPIO_DTGL, 32'h0000_00FF, 4'b1111);
        check("dtgl_gpio_o", {16'd0, gpio_o}, 32'h0000_005A);
        rd_reg(GPIO_DTGL, rv);
        check("dtgl_reads0", rv, 32'd0);
        rd_reg(GPIO_DOUT, rv);
        check("dout_after_tgl", rv, 32'h0000_005A);

        // OE: bits above GPIO_N ignored, per-lane update
        wr(GPIO_OE, 32'hFFFF_00F0, 4'b1111);
        check("oe_pins", {16'd0, gpio_oe}, 32'h0000_00F0);
        rd_reg(GPIO_OE, rv);
        check("oe_upper_zero", rv, 32'h0000_00F0);
        wr(GPIO_OE, 32'h0000_AB11, 4'b0010);
        rd_reg(GPIO_OE, rv);
        check("oe_lane1", rv, 32'h0000_ABF0);

        // Read and write of the same register in one cycle returns the old value
        waddr = GPIO_DOUT; wdat = 32'h77; sel = 4'b0001; we = 1'b1;
        raddr = GPIO_DOUT; rd = 1'b1;
        @(negedge clk);
        we = 1'b0; rd = 1'b0; sel = '0;
        check("rw_same_old", data_o, 32'h0000_005A);
        idle(3);
        check("data_o_hold", data_o, 32'h0000_005A);
        rd_reg(GPIO_DOUT, rv);
        check("rw_same_new", rv, 32'h0000_0077);
        check("gpio_o_77", {16'd0, gpio_o}, 32'h0000_0077);

        // Rising edge on pin 0: irq exactly two edges after the sampling edge
        wr(GPIO_IRISE, 32'h1, 4'b0001);
        wr(GPIO_IE, 32'h1, 4'b0001);
        pins[0] = 1'b1;          // stable before edge N
        idle(1);
        check("rise_irq_n", {31'd0, irq_o}, 32'd0);
        idle(1);
        check("rise_irq_n1", {31'd0, irq_o}, 32'd0);
        idle(1);
        check("rise_irq_n2", {31'd0, irq_o}, 32'd1);
        rd_reg(GPIO_IP, rv);
        check("rise_ip", rv, 32'h1);
        rd_reg(GPIO_DIN, rv);
        check("din_pin0", rv, 32'h1);
        wr(GPIO_IP, 32'h0, 4'b1111);
        rd_reg(GPIO_IP, rv);
        check("ip_w0_noeffect", rv, 32'h1);
        wr(GPIO_IP, 32'h1, 4'b0001);
        check("w1c_irq", {31'd0, irq_o}, 32'd0);
        rd_reg(GPIO_IP, rv);
        check("w1c_ip", rv, 32'h0);

        // Falling edge on pin 15 with IE[15]=0
        pins[15] = 1'b1;
        idle(4);
        rd_reg(GPIO_IP, rv);
        check("no_rise_cap15", rv, 32'h0);
        wr(GPIO_IFALL, 32'h0000_8000, 4'b0010);
        pins[15] = 1'b0;
        idle(4);
        rd_reg(GPIO_IP, rv);
        check("fall_ip15", rv, 32'h0000_8000);
        check("fall_irq_masked", {31'd0, irq_o}, 32'd0);
        wr(GPIO_IE, 32'h0000_8001, 4'b0011);
        check("fall_irq_ie", {31'd0, irq_o}, 32'd1);
        wr(GPIO_IP, 32'h0000_8000, 4'b0010);
        check("fall_clr_irq", {31'd0, irq_o}, 32'd0);

        // New rising edge on pin 0 in the same cycle as a W1C of IP[0]
        pins[0] = 1'b0;
        idle(4);
        rd_reg(GPIO_IP, rv);
        check("pin0_fall_nocap", rv, 32'h0);
        pins[0] = 1'b1;          // stable before edge N
        idle(2);
        wr(GPIO_IP, 32'h1, 4'b0001);  // write lands on edge N+2
        rd_reg(GPIO_IP, rv);
        check("set_wins_ip", rv, 32'h1);
        check("set_wins_irq", {31'd0, irq_o}, 32'd1);
        wr(GPIO_IP, 32'h1, 4'b0001);
        rd_reg(GPIO_IP, rv);
        check("set_wins_clear", rv, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
        // Prescaler restarts on the DBDIV write; ticks sample on every 10th edge.
        wr(GPIO_DBDIV, 32'd9, 4'b0011);
        idle(8);
        pins[3] = 1'b1;          // glitch whose synchronised image spans one tick
        idle(15);
        pins[3] = 1'b0;
        idle(40);
        rd_reg(GPIO_DIN, rv);
        check("deb_glitch", rv & 32'h8, 32'h0);
        pins[3] = 1'b1;
        idle(40);
        rd_reg(GPIO_DIN, rv);
        check("deb_level", rv & 32'h8, 32'h8);
        rd_reg(GPIO_DBDIV, rv);
        check("dbdiv_rd", rv, 32'd9);
`else
        wr(GPIO_DBDIV, 32'd9, 4'b1111);
        rd_reg(GPIO_DBDIV, rv);
        check("dbdiv_absent", rv, 32'd0);
`endif

        // Reset mid-operation: pins stop driving at once
        check("pre_rst_oe", {16'd0, gpio_oe}, 32'h0000_ABF0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_oe", {16'd0, gpio_oe}, 32'd0);
        check("midrst_o", {16'd0, gpio_o}, 32'd0);
        check("midrst_data_o", data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_reg(GPIO_IRISE, rv);
        check("midrst_irise", rv, 32'd0);

        // Summary
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
